// File: rtl/dp_ram_be_pipe_if.sv
// Request/response bundle for the dual-port byte-enable RAM.
// master drives requests, slave is the RAM.
interface dp_ram_be_pipe_if #(
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned DWIDTH = 32
);
    localparam int unsigned NB = DWIDTH / 8;

    logic              ena;
    logic [NB-1:0]     wea;
    logic [AWIDTH-1:0] addra;
    logic [DWIDTH-1:0] dina;
    logic [DWIDTH-1:0] douta;
    logic              valida;

    logic              enb;
    logic [NB-1:0]     web;
    logic [AWIDTH-1:0] addrb;
    logic [DWIDTH-1:0] dinb;
    logic [DWIDTH-1:0] doutb;
    logic              validb;

    logic              init_busy;
    logic              collision;

    modport master (
        output ena, wea, addra, dina, enb, web, addrb, dinb,
        input  douta, valida, doutb, validb, init_busy, collision
    );

    modport slave (
        input  ena, wea, addra, dina, enb, web, addrb, dinb,
        output douta, valida, doutb, validb, init_busy, collision
    );
endinterface

// File: rtl/dp_ram_be_pipe.sv
// True dual-port RAM with byte enables, selectable read-during-write,
// 1- or 2-cycle read pipeline, A-priority collision merge and post-reset clear.
module dp_ram_be_pipe #(
    parameter int unsigned AWIDTH         = 10,
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned WR_MODE        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dp_ram_be_pipe_if.slave   bus
);
    localparam int unsigned NB    = DWIDTH / 8;
    localparam int unsigned DEPTH = 2 ** AWIDTH;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    generate
        if ((DWIDTH % 8) != 0) begin : g_bad_dwidth
            $fatal(1, "dp_ram_be_pipe: DWIDTH must be a multiple of 8");
        end
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $fatal(1, "dp_ram_be_pipe: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;
    logic              collision_q, collision_d;

    logic [DWIDTH-1:0] douta1_q, douta1_d, doutb1_q, doutb1_d;
    logic              valida1_q, valida1_d, validb1_q, validb1_d;
    logic [DWIDTH-1:0] douta2_q, douta2_d, doutb2_q, doutb2_d;
    logic              valida2_q, valida2_d, validb2_q, validb2_d;

    logic              req_a, req_b, wr_a, wr_b, same_addr;
    logic [DWIDTH-1:0] old_a, old_b, fin_a, fin_b, rd_a, rd_b;

    // Final post-write word at each port's address; A wins on overlapping lanes.
    always_comb begin
        req_a     = bus.ena && (state_q == S_RUN);
        req_b     = bus.enb && (state_q == S_RUN);
        wr_a      = req_a && (bus.wea != '0);
        wr_b      = req_b && (bus.web != '0);
        same_addr = (bus.addra == bus.addrb);
        old_a     = mem_q[bus.addra];
        old_b     = mem_q[bus.addrb];
        fin_a     = old_a;
        fin_b     = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_a && bus.wea[i]) begin
                fin_a[8*i +: 8] = bus.dina[8*i +: 8];
            end else if (wr_b && bus.web[i] && same_addr) begin
                fin_a[8*i +: 8] = bus.dinb[8*i +: 8];
            end
            if (wr_a && bus.wea[i] && same_addr) begin
                fin_b[8*i +: 8] = bus.dina[8*i +: 8];
            end else if (wr_b && bus.web[i]) begin
                fin_b[8*i +: 8] = bus.dinb[8*i +: 8];
            end
        end
        // A non-writing port always sees the old word, even in write-first mode.
        rd_a = (WR_MODE == 1 && wr_a) ? fin_a : old_a;
        rd_b = (WR_MODE == 1 && wr_b) ? fin_b : old_b;
    end

    // Next-state, clear sequencing and read pipeline.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        busy_d      = busy_q;
        collision_d = 1'b0;
        douta1_d    = douta1_q;
        doutb1_d    = doutb1_q;
        valida1_d   = req_a;
        validb1_d   = req_b;
        douta2_d    = valida1_q ? douta1_q : douta2_q;
        doutb2_d    = validb1_q ? doutb1_q : doutb2_q;
        valida2_d   = valida1_q;
        validb2_d   = validb1_q;

        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AWIDTH'(1);
                if (clr_cnt_q == AWIDTH'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (req_a) begin
                    douta1_d = rd_a;
                end
                if (req_b) begin
                    doutb1_d = rd_b;
                end
                collision_d = wr_a && wr_b && same_addr && ((bus.wea & bus.web) != '0);
            end
            default: state_d = S_RUN;
        endcase

        busy_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_cnt_q   <= '0;
            busy_q      <= 1'(CLEAR_ON_RESET != 0);
            collision_q <= 1'b0;
            douta1_q    <= '0;
            doutb1_q    <= '0;
            valida1_q   <= 1'b0;
            validb1_q   <= 1'b0;
            douta2_q    <= '0;
            doutb2_q    <= '0;
            valida2_q   <= 1'b0;
            validb2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
            douta1_q    <= douta1_d;
            doutb1_q    <= doutb1_d;
            valida1_q   <= valida1_d;
            validb1_q   <= validb1_d;
            douta2_q    <= douta2_d;
            doutb2_q    <= doutb2_d;
            valida2_q   <= valida2_d;
            validb2_q   <= validb2_d;
        end
    end

    // Storage is never reset; on a shared address both ports write the same merged word.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == S_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                if (wr_a) begin
                    mem_q[bus.addra] <= fin_a;
                end
                if (wr_b) begin
                    mem_q[bus.addrb] <= fin_b;
                end
            end
        end
    end

    assign bus.douta     = (RD_LATENCY == 2) ? douta2_q  : douta1_q;
    assign bus.valida    = (RD_LATENCY == 2) ? valida2_q : valida1_q;
    assign bus.doutb     = (RD_LATENCY == 2) ? doutb2_q  : doutb1_q;
    assign bus.validb    = (RD_LATENCY == 2) ? validb2_q : validb1_q;
    assign bus.init_busy = busy_q;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_dp_ram_be_pipe.sv
// Scoreboard bench: dut0 is read-first/latency 1, dut1 is write-first/latency 2,
// both driven by the same directed stimulus.
module tb_dp_ram_be_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ena, enb;
    logic [3:0]  wea, web, addra, addrb;
    logic [31:0] dina, dinb;

    dp_ram_be_pipe_if #(.AWIDTH(4), .DWIDTH(32)) if0 ();
    dp_ram_be_pipe_if #(.AWIDTH(4), .DWIDTH(32)) if1 ();

    assign if0.ena = ena;   assign if1.ena = ena;
    assign if0.wea = wea;   assign if1.wea = wea;
    assign if0.addra = addra; assign if1.addra = addra;
    assign if0.dina = dina; assign if1.dina = dina;
    assign if0.enb = enb;   assign if1.enb = enb;
    assign if0.web = web;   assign if1.web = web;
    assign if0.addrb = addrb; assign if1.addrb = addrb;
    assign if0.dinb = dinb; assign if1.dinb = dinb;

    dp_ram_be_pipe #(.AWIDTH(4), .DWIDTH(32), .RD_LATENCY(1), .WR_MODE(0), .CLEAR_ON_RESET(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dp_ram_be_pipe #(.AWIDTH(4), .DWIDTH(32), .RD_LATENCY(2), .WR_MODE(1), .CLEAR_ON_RESET(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;

    // 0: dut0 A, 1: dut0 B, 2: dut1 A, 3: dut1 B
    sb_t sbq [4][$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    logic [31:0] img [8];

    always @(posedge clk) cyc++;

    task automatic mon(input int k, input logic v, input logic [31:0] d);
        sb_t e;
        if (v) begin
            total++;
            if (sbq[k].size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_valid[%0d] cyc=%0d got=%h required=no valid", k, cyc, d);
            end else begin
                e = sbq[k].pop_front();
                if (d !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL sb_read[%0d] got=%h@%0d required=%h@%0d", k, d, cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.valida, if0.douta);
        mon(1, if0.validb, if0.doutb);
        mon(2, if1.valida, if1.douta);
        mon(3, if1.validb, if1.doutb);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", nm, act, req);
        end
    endtask

    task automatic drv(input logic a_en, input logic [3:0] a_we, input logic [3:0] a_ad,
                       input logic [31:0] a_d, input logic b_en, input logic [3:0] b_we,
                       input logic [3:0] b_ad, input logic [31:0] b_d);
        ena = a_en; wea = a_we; addra = a_ad; dina = a_d;
        enb = b_en; web = b_we; addrb = b_ad; dinb = b_d;
    endtask

    task automatic idle();
        drv(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    // port 0 = A, 1 = B; e0 for read-first/lat1 DUT, e1 for write-first/lat2 DUT
    task automatic push(input int port, input logic [31:0] e0, input logic [31:0] e1);
        sb_t x0, x1;
        x0.data = e0; x0.cyc = cyc + 1;
        x1.data = e1; x1.cyc = cyc + 2;
        sbq[port].push_back(x0);
        sbq[port + 2].push_back(x1);
    endtask

    task automatic go();
        @(negedge clk);
    endtask

    task automatic count_busy(input string nm);
        int n0, n1;
        n0 = 0; n1 = 0;
        for (int n = 1; n <= 100 && (n0 == 0 || n1 == 0); n++) begin
            @(negedge clk);
            if (n0 == 0 && !if0.init_busy) n0 = n;
            if (n1 == 0 && !if1.init_busy) n1 = n;
        end
        idle();
        chk({nm, "_busy_cycles0"}, 32'(n0), 32'd16);
        chk({nm, "_busy_cycles1"}, 32'(n1), 32'd16);
    endtask

    initial begin
        idle();
        img[0] = 32'h0; img[1] = 32'h0; img[2] = 32'h0; img[3] = 32'h44443333;
        img[4] = 32'h0; img[5] = 32'hAA22CC44; img[6] = 32'h0; img[7] = 32'h2;

        repeat (3) go();
        chk("rst_douta0", if0.douta, 32'h0);
        chk("rst_doutb0", if0.doutb, 32'h0);
        chk("rst_douta1", if1.douta, 32'h0);
        chk("rst_doutb1", if1.doutb, 32'h0);
        chk("rst_flags0", {28'h0, if0.valida, if0.validb, if0.collision, if0.init_busy}, 32'h1);
        chk("rst_flags1", {28'h0, if1.valida, if1.validb, if1.collision, if1.init_busy}, 32'h1);
        rst_n = 1'b1;
        count_busy("clear1");

        // Cleared contents on both ports
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0);
            push(0, 32'h0, 32'h0);
            push(1, 32'h0, 32'h0);
            go();
        end

        // Byte enables
        drv(1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 4'h0, 4'h0, 32'h0);
        push(0, 32'h0, 32'hAABBCCDD); go();
        drv(1'b1, 4'h5, 4'd5, 32'h11223344, 1'b0, 4'h0, 4'h0, 32'h0);
        push(0, 32'hAABBCCDD, 32'hAA22CC44); go();
        drv(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
        push(1, 32'hAA22CC44, 32'hAA22CC44); go();

        // Read-during-write, same port and cross port
        drv(1'b1, 4'hF, 4'd7, 32'h1, 1'b0, 4'h0, 4'h0, 32'h0);
        push(0, 32'h0, 32'h1); go();
        drv(1'b1, 4'hF, 4'd7, 32'h2, 1'b1, 4'h0, 4'd7, 32'h0);
        push(0, 32'h1, 32'h2); push(1, 32'h1, 32'h1); go();
        drv(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
        push(1, 32'h2, 32'h2); go();

        // Collision with overlapping lane 1
        drv(1'b1, 4'h3, 4'd3, 32'h11111111, 1'b1, 4'h6, 4'd3, 32'h22222222);
        push(0, 32'h0, 32'h00221111); push(1, 32'h0, 32'h00221111); go();
        chk("coll_pulse0", 32'(if0.collision), 32'h1);
        chk("coll_pulse1", 32'(if1.collision), 32'h1);
        idle(); go();
        chk("coll_drop0", 32'(if0.collision), 32'h0);
        chk("coll_drop1", 32'(if1.collision), 32'h0);
        // Same address, disjoint lanes
        drv(1'b1, 4'h3, 4'd3, 32'h33333333, 1'b1, 4'hC, 4'd3, 32'h44444444);
        push(0, 32'h00221111, 32'h44443333); push(1, 32'h00221111, 32'h44443333); go();
        chk("nocoll0", 32'(if0.collision), 32'h0);
        chk("nocoll1", 32'(if1.collision), 32'h0);
        drv(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
        push(1, 32'h44443333, 32'h44443333); go();

        // Streaming reads, then hold
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
            push(0, img[i], img[i]);
            go();
        end
        idle();
        repeat (4) go();
        chk("hold_douta0", if0.douta, 32'h2);
        chk("hold_douta1", if1.douta, 32'h2);
        chk("hold_doutb0", if0.doutb, 32'h44443333);
        chk("hold_doutb1", if1.doutb, 32'h44443333);
        chk("hold_valid", {30'h0, if0.valida, if1.valida}, 32'h0);

        // Reset, then reset again mid-clear with requests held active
        rst_n = 1'b0; go();
        chk("rst2_douta0", if0.douta, 32'h0);
        chk("rst2_douta1", if1.douta, 32'h0);
        rst_n = 1'b1;
        drv(1'b1, 4'hF, 4'd0, 32'hDEADBEEF, 1'b1, 4'hF, 4'd1, 32'hCAFEF00D);
        repeat (9) go();
        rst_n = 1'b0; go();
        rst_n = 1'b1;
        count_busy("clear2");

        drv(1'b1, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd1, 32'h0);
        push(0, 32'h0, 32'h0); push(1, 32'h0, 32'h0); go();
        drv(1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
        push(0, 32'h0, 32'h0); push(1, 32'h0, 32'h0); go();
        idle();

        for (int n = 0; n < 20 && (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0; n++)
            go();
        go();
        total++;
        if ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0",
                     sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
